cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Front-panel run controller between the push-button inputs and the CPU core inside the FPGA top level. It debounces and edge-detects the 5 buttons and runs a run/halt/single-step/soft-reset state machine. That state machine drives the CPU clock enable and the CPU reset. It also keeps a wrap-around LED view selector.

Parameters:
DEB_CYCLES, 20000, consecutive stable cycles required before a debounced button changes state.
DEB_W, 15, width of the debounce counter; must satisfy 2**DEB_W > DEB_CYCLES.
SRST_CYCLES, 16, number of cycles cpu_rst_n is held low in the SRST state.

Ports:
clk  in  1  system clock (post clock-wizard domain).
rst_n  in  1  asynchronous active-low reset, named as in the codebase; the polarity and synchronicity here are fixed.
pb  in  5  raw buttons, asynchronous; [0] run/halt toggle, [1] single step, [2] soft reset, [3] view next, [4] view prev.
halt_req  in  1  CPU retired a HALT instruction; level, sampled every cycle.
cpu_en  out  1  CPU clock enable.
cpu_rst_n  out  1  synchronous active-low reset to the CPU core.
disp_sel  out  2  LED view select.
run_state  out  2  current FSM state encoding, for the LEDs.

Behaviour:
- Reset (rst_n=0), all registers asynchronously cleared:
  - FSM enters SRST with its counter at 0.
  - cpu_en=0, cpu_rst_n=0, disp_sel=0, run_state=SRST.
  - Debounced button levels are 0.
- Button input path, per button:
  - 2-flop synchronizer.
  - Debouncer: the counter increments while the synchronized input differs from the debounced level and clears when they match.
  - When the counter reaches DEB_CYCLES-1, the debounced level flips and the counter clears.
  - A 0->1 flip of the debounced level produces a 1-cycle press pulse in the following cycle.
  - Glitches shorter than DEB_CYCLES produce no pulse. Release produces no pulse.
- FSM states and encoding: HALTED=0, RUN=1, STEP=2, SRST=3. Transitions use press pulses with priority srst > run > step.
  - SRST: cpu_rst_n=0, cpu_en=0. The counter counts up to SRST_CYCLES-1, then the FSM goes to HALTED. An srst pulse while in SRST restarts the count.
  - HALTED: cpu_en=0, cpu_rst_n=1. srst pulse -> SRST; run pulse -> RUN; step pulse -> STEP.
  - RUN: cpu_en=1. srst pulse -> SRST; run pulse -> HALTED; halt_req=1 -> HALTED. Step pulse is ignored.
  - STEP: cpu_en=1 for exactly one cycle, then HALTED unconditionally. An srst pulse in this cycle goes to SRST instead. run pulse and halt_req are ignored.
- Output timing:
  - cpu_en, cpu_rst_n and run_state are Moore outputs decoded from the registered state; no combinational path from any input.
  - cpu_en falls in the cycle after halt_req is sampled high in RUN.
  - Latency from a raw button edge to the state change is 2 (sync) + DEB_CYCLES + 1 (pulse) + 1 (state) cycles.
- disp_sel:
  - Increments modulo 4 on a view-next pulse (3 -> 0) and decrements on a view-prev pulse (0 -> 3).
  - Both pulses in the same cycle: no change.
  - Unaffected by SRST; cleared only by rst_n.
- rst_n asserted mid-operation (e.g. in RUN) forces SRST immediately. The debouncers clear, so a button held through reset produces one press pulse DEB_CYCLES+3 cycles after reset release.

Decomposition:
- Package cpu_run_ctrl_pkg holds:
  - the run_state enum (HALTED/RUN/STEP/SRST with the encodings above);
  - button index constants PB_RUN=0, PB_STEP=1, PB_SRST=2, PB_NEXT=3, PB_PREV=4.
- One sub-module, pb_debounce: single button with synchronizer, debounce counter and press-pulse output, parameterised by DEB_CYCLES/DEB_W. It is instantiated 5 times.

Test Plan (DEB_CYCLES=4, SRST_CYCLES=4):
- Reset release, no buttons -> cpu_rst_n=0 for 4 cycles, then 1; run_state=0; cpu_en=0 throughout.
- pb[0] held 10 cycles from HALTED -> run_state=1 and cpu_en=1 exactly 8 cycles after the raw edge; a second press -> cpu_en=0 and run_state=0.
- pb[0] glitch high for 3 cycles -> no pulse, state stays HALTED.
- From HALTED, press pb[1] -> cpu_en high for exactly 1 cycle, then run_state=0.
- In RUN, drive halt_req=1 for one cycle -> cpu_en=0 on the next cycle, run_state=0.
- pb[3] and pb[4] pressed simultaneously -> disp_sel unchanged. pb[4] from 0 -> 3. pb[2] pressed during RUN -> cpu_rst_n=0 for 4 cycles, then HALTED, with disp_sel retained.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared run-state encoding and front-panel button indices
package cpu_run_ctrl_pkg;
  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    SRST   = 2'd3
  } run_state_e;
  localparam int PB_RUN  = 0;
  localparam int PB_STEP = 1;
  localparam int PB_SRST = 2;
  localparam int PB_NEXT = 3;
  localparam int PB_PREV = 4;
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: one button -> 2-flop sync, debounce counter, 1-cycle press pulse
//   clk, rst_n : system clock, async active-low reset
//   pb         : raw asynchronous button
//   press      : 1-cycle pulse one cycle after the debounced level rises
module pb_debounce #(
  parameter int DEB_CYCLES = 20000,
  parameter int DEB_W      = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic press
);
  logic             r_s1, r_s2, r_deb, r_deb_d, r_press;
  logic [DEB_W-1:0] r_cnt;
  logic             w_diff, w_flip;
  assign w_diff = r_s2 ^ r_deb;
  assign w_flip = w_diff && (r_cnt == DEB_W'(DEB_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= pb;
      r_s2    <= r_s1;
      r_cnt   <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
      r_deb   <= r_deb ^ w_flip;
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
    end
  end
  assign press = r_press;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: front-panel run/halt/step/soft-reset controller and LED view selector
//   clk, rst_n : system clock, async active-low reset
//   pb[4:0]    : raw buttons {prev, next, srst, step, run}
//   halt_req   : CPU retired HALT (level)
//   cpu_en     : CPU clock enable
//   cpu_rst_n  : sync active-low CPU reset
//   disp_sel   : LED view select
//   run_state  : current state encoding
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = 20000,
  parameter int DEB_W       = 15,
  parameter int SRST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] pb,
  input  logic       halt_req,
  output logic       cpu_en,
  output logic       cpu_rst_n,
  output logic [1:0] disp_sel,
  output logic [1:0] run_state
);
  localparam int SW = $clog2(SRST_CYCLES + 1);
  logic [4:0]    w_press;
  run_state_e    r_state, w_state_nx;
  logic [SW-1:0] r_cnt, w_cnt_nx;
  logic [1:0]    r_disp;
  for (genvar i = 0; i < 5; i++) begin : g_deb
    pb_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .pb   (pb[i]),
      .press(w_press[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SRST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
  // The counter only matters in SRST; every entry into SRST starts it at 0.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = '0;
    case (r_state)
      SRST: begin
        if (!w_press[PB_SRST] && r_cnt == SW'(SRST_CYCLES - 1)) w_state_nx = HALTED;
        else if (!w_press[PB_SRST]) w_cnt_nx = r_cnt + 1'b1;
      end
      HALTED: w_state_nx = w_press[PB_SRST] ? SRST :
                           w_press[PB_RUN]  ? RUN  :
                           w_press[PB_STEP] ? STEP : HALTED;
      RUN:    w_state_nx = w_press[PB_SRST] ? SRST :
                           (w_press[PB_RUN] || halt_req) ? HALTED : RUN;
      STEP:   w_state_nx = w_press[PB_SRST] ? SRST : HALTED;
      default: w_state_nx = SRST;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_disp <= 2'd0;
    else if (w_press[PB_NEXT] ^ w_press[PB_PREV])
      r_disp <= w_press[PB_NEXT] ? r_disp + 2'd1 : r_disp - 2'd1;
  end
  assign cpu_en    = (r_state == RUN) || (r_state == STEP);
  assign cpu_rst_n = r_state != SRST;
  assign run_state = r_state;
  assign disp_sel  = r_disp;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboarded random + directed bench for cpu_run_ctrl
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;
  localparam int DEB  = 4;
  localparam int SRC  = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] pb = '0;
  logic       halt_req = 1'b0;
  logic       cpu_en, cpu_rst_n;
  logic [1:0] disp_sel, run_state;
  int errors = 0;
  int checks = 0;
  cpu_run_ctrl #(.DEB_CYCLES(DEB), .DEB_W(3), .SRST_CYCLES(SRC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pb       (pb),
    .halt_req (halt_req),
    .cpu_en   (cpu_en),
    .cpu_rst_n(cpu_rst_n),
    .disp_sel (disp_sel),
    .run_state(run_state)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic       en;
    logic       rn;
    logic [1:0] disp;
    logic [1:0] st;
  } exp_t;
  exp_t q[$];
  int         t = 0;
  run_state_e m_st;
  int         m_scnt;
  logic [1:0] m_disp;
  logic [4:0] d1, d2, deb, rose, pulse;
  int         last_agree[5];
  task automatic chk(string name, logic [5:0] act, logic [5:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask
  task automatic model_reset();
    m_st = SRST; m_scnt = 0; m_disp = 2'd0;
    d1 = '0; d2 = '0; deb = '0; rose = '0; pulse = '0;
    for (int b = 0; b < 5; b++) last_agree[b] = t;
  endtask
  // Abstract model: a button's synchronised view is its raw value two edges ago;
  // the debounced level flips once DEB edges in a row have disagreed with it,
  // and a rise is announced one edge later as the press seen by the FSM.
  task automatic model_step(input logic [4:0] p, input logic h);
    logic [4:0] sync;
    case (m_st)
      SRST:
        if (pulse[PB_SRST]) m_scnt = 0;
        else if (m_scnt == SRC - 1) m_st = HALTED;
        else m_scnt++;
      HALTED:
        if (pulse[PB_SRST]) begin m_st = SRST; m_scnt = 0; end
        else if (pulse[PB_RUN]) m_st = RUN;
        else if (pulse[PB_STEP]) m_st = STEP;
      RUN:
        if (pulse[PB_SRST]) begin m_st = SRST; m_scnt = 0; end
        else if (pulse[PB_RUN] || h) m_st = HALTED;
      default:
        if (pulse[PB_SRST]) begin m_st = SRST; m_scnt = 0; end
        else m_st = HALTED;
    endcase
    if (pulse[PB_NEXT] && !pulse[PB_PREV]) m_disp = m_disp + 2'd1;
    if (pulse[PB_PREV] && !pulse[PB_NEXT]) m_disp = m_disp + 2'd3;
    sync = d2; d2 = d1; d1 = p;
    pulse = rose; rose = '0;
    for (int b = 0; b < 5; b++) begin
      if (sync[b] == deb[b]) last_agree[b] = t;
      else if (t - last_agree[b] == DEB) begin
        deb[b] = ~deb[b];
        last_agree[b] = t;
        if (deb[b]) rose[b] = 1'b1;
      end
    end
  endtask
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      t++;
      if (!rst_n) model_reset();
      else model_step(pb, halt_req);
      q.push_back('{m_st == RUN || m_st == STEP, m_st != SRST, m_disp, m_st});
      #2;
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_outputs", {cpu_en, cpu_rst_n, disp_sel, run_state}, e);
    end
  end
  initial begin
    int n;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    chk("srst_hold_rst_n", 6'(cpu_rst_n), 6'd0);
    cyc(1);
    chk("srst_done_rst_n", 6'(cpu_rst_n), 6'd1);
    chk("srst_done_state", 6'(run_state), 6'(HALTED));
    pb[PB_RUN] = 1'b1;
    cyc(7);
    chk("run_lat_early", 6'(run_state), 6'(HALTED));
    cyc(1);
    chk("run_lat_state", 6'(run_state), 6'(RUN));
    chk("run_lat_en", 6'(cpu_en), 6'd1);
    cyc(2);
    pb[PB_RUN] = 1'b0;
    cyc(8);
    pb[PB_RUN] = 1'b1;
    cyc(10);
    pb[PB_RUN] = 1'b0;
    cyc(8);
    chk("run_toggle_state", 6'(run_state), 6'(HALTED));
    chk("run_toggle_en", 6'(cpu_en), 6'd0);
    pb[PB_RUN] = 1'b1;
    cyc(3);
    pb[PB_RUN] = 1'b0;
    cyc(10);
    chk("glitch_state", 6'(run_state), 6'(HALTED));
    pb[PB_STEP] = 1'b1;
    cyc(8);
    chk("step_en", 6'(cpu_en), 6'd1);
    chk("step_state", 6'(run_state), 6'(STEP));
    cyc(1);
    chk("step_after_en", 6'(cpu_en), 6'd0);
    chk("step_after_state", 6'(run_state), 6'(HALTED));
    pb[PB_STEP] = 1'b0;
    cyc(8);
    pb[PB_RUN] = 1'b1;
    cyc(8);
    pb[PB_RUN] = 1'b0;
    cyc(8);
    chk("halt_pre_state", 6'(run_state), 6'(RUN));
    halt_req = 1'b1;
    cyc(1);
    halt_req = 1'b0;
    chk("halt_en", 6'(cpu_en), 6'd0);
    chk("halt_state", 6'(run_state), 6'(HALTED));
    pb[4:3] = 2'b11;
    cyc(10);
    pb = '0;
    cyc(8);
    chk("disp_both", 6'(disp_sel), 6'd0);
    pb[PB_PREV] = 1'b1;
    cyc(10);
    pb = '0;
    cyc(8);
    chk("disp_prev_wrap", 6'(disp_sel), 6'd3);
    pb[PB_RUN] = 1'b1;
    cyc(8);
    pb[PB_RUN] = 1'b0;
    cyc(8);
    pb[PB_SRST] = 1'b1;
    cyc(8);
    chk("srst_btn_rst_n", 6'(cpu_rst_n), 6'd0);
    chk("srst_btn_state", 6'(run_state), 6'(SRST));
    pb[PB_SRST] = 1'b0;
    cyc(3);
    chk("srst_btn_hold", 6'(cpu_rst_n), 6'd0);
    cyc(1);
    chk("srst_btn_done", 6'(run_state), 6'(HALTED));
    chk("srst_btn_disp", 6'(disp_sel), 6'd3);
    pb[PB_RUN] = 1'b1;
    cyc(10);
    chk("midrst_pre", 6'(run_state), 6'(RUN));
    #5 rst_n = 1'b0;
    #1;
    chk("midrst_async_state", 6'(run_state), 6'(SRST));
    chk("midrst_async_en", 6'(cpu_en), 6'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(7);
    chk("held_thru_rst_early", 6'(run_state), 6'(HALTED));
    cyc(1);
    chk("held_thru_rst_run", 6'(run_state), 6'(RUN));
    pb = '0;
    cyc(8);
    repeat (200) begin
      pb = 5'($urandom & $urandom);
      n = $urandom_range(1, 10);
      repeat (n) begin
        halt_req = ($urandom_range(0, 7) == 0);
        cyc(1);
      end
    end
    pb = '0;
    halt_req = 1'b0;
    cyc(2);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
